rtc_bcd_timekeeper: RTL and testbench
=====================================

Name: rtc_bcd_timekeeper

Overview:
- Parametrised successor of the team's six-digit real-time clock.
- Keeps time as BCD HH:MM:SS, advanced by an internal prescaler derived from the system clock. Adds run/pause, synchronous time load with validation, 12/24-hour display mode and a seconds strobe.
- Drives six 7-segment digit outputs for the board display.
- Sits between the board clock and the display mux.

Parameters:
- CLK_HZ, 50000000, system clock cycles per second (prescaler terminal count + 1); minimum 2.
- SEG_ACT_LOW, 1, 1 = segment bit 0 lights (digit 0 = 7'b0000001, order abcdefg MSB..LSB); 0 = all segment bits inverted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- run_en  in  1  1 = prescaler counts; 0 = time frozen, prescaler holds.
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display; affects display only.
- load  in  1  single-cycle request to load set_time.
- set_time  in  24  BCD {H10,H1,M10,M1,S10,S1}, 4 bits each.
- load_err  out  1  one-cycle pulse when a load is rejected.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- pm  out  1  1 when internal hour >= 12.
- seg_hr_m, seg_hr_l, seg_min_m, seg_min_l, seg_sec_m, seg_sec_l  out  7 each  registered digit segments.

Behaviour:
- Reset (async, immediate):
  - prescaler = 0; time = 00:00:00.
  - load_err = 0, sec_tick = 0, pm = 0.
  - All six seg outputs = encoding of digit 0.
- Prescaler:
  - When run_en = 1, counts 0..CLK_HZ-1.
  - Wraps at CLK_HZ-1 and asserts an internal tick in that cycle.
  - When run_en = 0, holds its value; no tick.
- Tick advance (one clock, registered):
  - S1 9->0 carries into S10; S10:S1 = 59 -> 00 carries into M1.
  - Minutes behave identically and carry into hours.
  - Hours 23 -> 00 on carry; 09 -> 10 and 19 -> 20 by H1 carry.
  - Full rollover 23:59:59 -> 00:00:00 happens in a single tick.
  - sec_tick is registered and pulses the cycle after the tick, together with the updated time.
- Load:
  - A load is valid when every nibble is <= 9, S10 <= 5, M10 <= 5, and H10:H1 <= 23.
  - On a valid load: time = set_time next cycle, prescaler clears to 0, no tick that cycle.
  - Load has priority over a coincident tick; the tick is discarded.
  - On an invalid load: time and prescaler unchanged, prescaler continues counting, load_err = 1 for exactly one cycle.
  - A load is accepted regardless of run_en.
- Display (registered, 1-cycle latency from time state):
  - In 24-hour mode, hour digits show the internal hour.
  - In 12-hour mode, internal hour 00 displays 12; 01-12 display unchanged; 13-23 display the hour minus 12.
  - In 12-hour mode a display hour tens digit of 0 is blanked (all segments off).
  - pm is registered from the internal hour, independent of mode.
  - Digit encodings for SEG_ACT_LOW = 1: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100.
  - Blank and any nibble > 9 map to 1111111.
  - For SEG_ACT_LOW = 0, all seven bits are inverted.
- Changes to mode_12h take effect on the display one cycle later; time state is unaffected.

Optional Feature:
- Macro RTC_ALARM_EN.
- Defined:
  - Adds inputs alarm_time (16, BCD HH:MM), alarm_arm (1) and alarm_clr (1), and output alarm (1).
  - alarm sets on the tick that makes time equal alarm_time:00 while alarm_arm = 1.
  - alarm stays high until alarm_clr or alarm_arm = 0.
  - A load that lands exactly on the alarm time does not trigger it.
  - alarm resets to 0.
- Undefined: the alarm ports and logic are absent; all other behaviour is identical.

Test Plan:
- CLK_HZ = 4, run_en = 1 from reset -> sec_tick every 4 cycles; after 40 cycles the seconds digits show 10.
- Load 0x235958, then 2 ticks -> 23:59:59 followed by 00:00:00; pm goes 1 -> 0.
- Load 0x136000 (S/M invalid) and 0x240000 -> load_err pulses once each; time is unchanged.
- Load coincident with a tick -> loaded value held; the next sec_tick comes exactly CLK_HZ cycles after the load.
- mode_12h = 1 at 00:xx, 12:xx and 13:05 -> display shows 12, 12 and 1 with blanked H10; pm = 0, 1, 1.
- run_en = 0 for 20 cycles -> no sec_tick and time frozen; re-enable resumes from the held prescaler count.

Source files
------------

// File: rtl/rtc_bcd_timekeeper.sv
// rtc_bcd_timekeeper: six-digit BCD real-time clock (HH:MM:SS).
// An internal prescaler turns the system clock into one tick per second.
// The block adds run/pause, a validated time load, a 12/24-hour display,
// a seconds strobe and registered 7-segment outputs for the display mux.
// Optional alarm comparator: define RTC_ALARM_EN to include it.
module rtc_bcd_timekeeper #(
    parameter int CLK_HZ      = 50000000,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_en,
    input  logic        mode_12h,
    input  logic        load,
    input  logic [23:0] set_time,
`ifdef RTC_ALARM_EN
    input  logic [15:0] alarm_time,
    input  logic        alarm_arm,
    input  logic        alarm_clr,
    output logic        alarm,
`endif
    output logic        load_err,
    output logic        sec_tick,
    output logic        pm,
    output logic [6:0]  seg_hr_m,
    output logic [6:0]  seg_hr_l,
    output logic [6:0]  seg_min_m,
    output logic [6:0]  seg_min_l,
    output logic [6:0]  seg_sec_m,
    output logic [6:0]  seg_sec_l
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [6:0] SEG_ZERO = (SEG_ACT_LOW != 0) ? 7'b0000001 : 7'b1111110;

    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;
    logic          sec_tick_q, sec_tick_d;
    logic          load_err_q, load_err_d;
    logic          pm_q, pm_d;
    logic [6:0]    seg_hr_m_q, seg_hr_m_d, seg_hr_l_q, seg_hr_l_d;
    logic [6:0]    seg_min_m_q, seg_min_m_d, seg_min_l_q, seg_min_l_d;
    logic [6:0]    seg_sec_m_q, seg_sec_m_d, seg_sec_l_q, seg_sec_l_d;

    logic          tick;
    logic          load_ok;
    logic          load_take;
    logic [23:0]   time_inc;
    logic [4:0]    hour_bin;
    logic [4:0]    disp_hour;
    logic          disp_tens;
    logic [3:0]    disp_units;

    // Raw pattern is active-low (0 lights a segment); invert for active-high boards.
    function automatic logic [6:0] seg_enc(input logic [3:0] d, input logic blank);
        logic [6:0] raw;
        case (d)
            4'd0:    raw = 7'b0000001;
            4'd1:    raw = 7'b1001111;
            4'd2:    raw = 7'b0010010;
            4'd3:    raw = 7'b0000110;
            4'd4:    raw = 7'b1001100;
            4'd5:    raw = 7'b0100100;
            4'd6:    raw = 7'b0100000;
            4'd7:    raw = 7'b0001111;
            4'd8:    raw = 7'b0000000;
            4'd9:    raw = 7'b0000100;
            default: raw = 7'b1111111;
        endcase
        if (blank) raw = 7'b1111111;
        return (SEG_ACT_LOW != 0) ? raw : ~raw;
    endfunction

    // Load validation and the one-second tick from the prescaler terminal count.
    always_comb begin
        load_ok = (set_time[3:0]   <= 4'd9) && (set_time[7:4]   <= 4'd5) &&
                  (set_time[11:8]  <= 4'd9) && (set_time[15:12] <= 4'd5) &&
                  (set_time[19:16] <= 4'd9) &&
                  ((set_time[23:20] < 4'd2) ||
                   ((set_time[23:20] == 4'd2) && (set_time[19:16] <= 4'd3)));
        load_take = load && load_ok;
        tick      = run_en && (presc_q == PRESC_MAX);
    end

    // BCD time plus one second, rippling carries through minutes and hours.
    always_comb begin
        time_inc = time_q;
        if (time_inc[3:0] != 4'd9) begin
            time_inc[3:0] = time_inc[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (time_inc[7:4] != 4'd5) begin
                time_inc[7:4] = time_inc[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (time_inc[11:8] != 4'd9) begin
                    time_inc[11:8] = time_inc[11:8] + 4'd1;
                end else begin
                    time_inc[11:8] = 4'd0;
                    if (time_inc[15:12] != 4'd5) begin
                        time_inc[15:12] = time_inc[15:12] + 4'd1;
                    end else begin
                        time_inc[15:12] = 4'd0;
                        if ((time_inc[23:20] == 4'd2) && (time_inc[19:16] == 4'd3)) begin
                            time_inc[23:16] = 8'h00;
                        end else if (time_inc[19:16] == 4'd9) begin
                            time_inc[19:16] = 4'd0;
                            time_inc[23:20] = time_inc[23:20] + 4'd1;
                        end else begin
                            time_inc[19:16] = time_inc[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Next time/prescaler: a valid load wins over a coincident tick, which is dropped.
    always_comb begin
        presc_d    = presc_q;
        time_d     = time_q;
        sec_tick_d = 1'b0;
        load_err_d = 1'b0;
        if (load_take) begin
            time_d  = set_time;
            presc_d = '0;
        end else begin
            load_err_d = load;
            if (tick) begin
                presc_d    = '0;
                time_d     = time_inc;
                sec_tick_d = 1'b1;
            end else if (run_en) begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Display digits: 12-hour mode maps 00 to 12, 13-23 down by 12 and blanks a leading zero.
    always_comb begin
        hour_bin   = 5'(time_q[23:20]) * 5'd10 + 5'(time_q[19:16]);
        pm_d       = (hour_bin >= 5'd12);
        disp_hour  = hour_bin;
        if (hour_bin == 5'd0) begin
            disp_hour = 5'd12;
        end else if (hour_bin > 5'd12) begin
            disp_hour = hour_bin - 5'd12;
        end
        disp_tens  = (disp_hour >= 5'd10);
        disp_units = disp_tens ? 4'(disp_hour - 5'd10) : 4'(disp_hour);
        if (mode_12h) begin
            seg_hr_m_d = seg_enc(4'd1, !disp_tens);
            seg_hr_l_d = seg_enc(disp_units, 1'b0);
        end else begin
            seg_hr_m_d = seg_enc(time_q[23:20], 1'b0);
            seg_hr_l_d = seg_enc(time_q[19:16], 1'b0);
        end
        seg_min_m_d = seg_enc(time_q[15:12], 1'b0);
        seg_min_l_d = seg_enc(time_q[11:8], 1'b0);
        seg_sec_m_d = seg_enc(time_q[7:4], 1'b0);
        seg_sec_l_d = seg_enc(time_q[3:0], 1'b0);
    end

    // State and display registers; reset shows 00:00:00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            time_q      <= 24'h000000;
            sec_tick_q  <= 1'b0;
            load_err_q  <= 1'b0;
            pm_q        <= 1'b0;
            seg_hr_m_q  <= SEG_ZERO;
            seg_hr_l_q  <= SEG_ZERO;
            seg_min_m_q <= SEG_ZERO;
            seg_min_l_q <= SEG_ZERO;
            seg_sec_m_q <= SEG_ZERO;
            seg_sec_l_q <= SEG_ZERO;
        end else begin
            presc_q     <= presc_d;
            time_q      <= time_d;
            sec_tick_q  <= sec_tick_d;
            load_err_q  <= load_err_d;
            pm_q        <= pm_d;
            seg_hr_m_q  <= seg_hr_m_d;
            seg_hr_l_q  <= seg_hr_l_d;
            seg_min_m_q <= seg_min_m_d;
            seg_min_l_q <= seg_min_l_d;
            seg_sec_m_q <= seg_sec_m_d;
            seg_sec_l_q <= seg_sec_l_d;
        end
    end

`ifdef RTC_ALARM_EN
    logic alarm_q, alarm_d;

    // Alarm latches only on a real tick reaching HH:MM:00, never on a load.
    always_comb begin
        alarm_d = alarm_q;
        if (!alarm_arm || alarm_clr) begin
            alarm_d = 1'b0;
        end else if (tick && !load_take && (time_inc == {alarm_time, 8'h00})) begin
            alarm_d = 1'b1;
        end
    end

    // Alarm flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign load_err  = load_err_q;
    assign sec_tick  = sec_tick_q;
    assign pm        = pm_q;
    assign seg_hr_m  = seg_hr_m_q;
    assign seg_hr_l  = seg_hr_l_q;
    assign seg_min_m = seg_min_m_q;
    assign seg_min_l = seg_min_l_q;
    assign seg_sec_m = seg_sec_m_q;
    assign seg_sec_l = seg_sec_l_q;

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Testbench for rtc_bcd_timekeeper with a 4-cycle second.
module tb_rtc_bcd_timekeeper;

    logic        clk;
    logic        rst;
    logic        run_en;
    logic        mode_12h;
    logic        load;
    logic [23:0] set_time;
    logic        load_err;
    logic        sec_tick;
    logic        pm;
    logic [6:0]  seg_hr_m, seg_hr_l, seg_min_m, seg_min_l, seg_sec_m, seg_sec_l;
    logic [41:0] segs_all;
`ifdef RTC_ALARM_EN
    logic        alarm;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] set_time;
        logic        mode;
        logic        exp_err;
        logic [23:0] exp_disp;
        logic        exp_pm;
    } vec_t;

    vec_t vecs [13];
    vec_t exp_q [$];

    rtc_bcd_timekeeper #(.CLK_HZ(4), .SEG_ACT_LOW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_en    (run_en),
        .mode_12h  (mode_12h),
        .load      (load),
        .set_time  (set_time),
`ifdef RTC_ALARM_EN
        .alarm_time(16'h0000),
        .alarm_arm (1'b0),
        .alarm_clr (1'b0),
        .alarm     (alarm),
`endif
        .load_err  (load_err),
        .sec_tick  (sec_tick),
        .pm        (pm),
        .seg_hr_m  (seg_hr_m),
        .seg_hr_l  (seg_hr_l),
        .seg_min_m (seg_min_m),
        .seg_min_l (seg_min_l),
        .seg_sec_m (seg_sec_m),
        .seg_sec_l (seg_sec_l)
    );

    assign segs_all = {seg_hr_m, seg_hr_l, seg_min_m, seg_min_l, seg_sec_m, seg_sec_l};

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Active-low segment patterns; nibble F (or any non-digit) means blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp_of(input logic [23:0] v);
        return {seg_of(v[23:20]), seg_of(v[19:16]), seg_of(v[15:12]),
                seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        load     = 1'b1;
        set_time = v.set_time;
        mode_12h = v.mode;
        exp_q.push_back(v);
    endtask

    task automatic scoreVector(input int idx);
        vec_t v;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty vec%0d actual=0 expected=1", idx);
            return;
        end
        v = exp_q.pop_front();
        @(posedge clk); #1;
        load = 1'b0;
        checkOutput($sformatf("load_err_pulse_vec%0d", idx), 64'(load_err), 64'(v.exp_err));
        @(posedge clk); #1;
        checkOutput($sformatf("load_err_clear_vec%0d", idx), 64'(load_err), 64'(0));
        checkOutput($sformatf("display_vec%0d", idx), 64'(segs_all), 64'(disp_of(v.exp_disp)));
        checkOutput($sformatf("pm_vec%0d", idx), 64'(pm), 64'(v.exp_pm));
    endtask

    initial begin
        vecs[0]  = '{24'h235958, 1'b0, 1'b0, 24'h235958, 1'b1};
        vecs[1]  = '{24'h136000, 1'b0, 1'b1, 24'h235958, 1'b1};
        vecs[2]  = '{24'h240000, 1'b0, 1'b1, 24'h235958, 1'b1};
        vecs[3]  = '{24'h003000, 1'b1, 1'b0, 24'h123000, 1'b0};
        vecs[4]  = '{24'h121500, 1'b1, 1'b0, 24'h121500, 1'b1};
        vecs[5]  = '{24'h130500, 1'b1, 1'b0, 24'hF10500, 1'b1};
        vecs[6]  = '{24'h103000, 1'b1, 1'b0, 24'h103000, 1'b0};
        vecs[7]  = '{24'h130500, 1'b0, 1'b0, 24'h130500, 1'b1};
        vecs[8]  = '{24'h0A0000, 1'b0, 1'b1, 24'h130500, 1'b1};
        vecs[9]  = '{24'h095900, 1'b0, 1'b0, 24'h095900, 1'b0};
        vecs[10] = '{24'h195959, 1'b1, 1'b0, 24'hF75959, 1'b1};
        vecs[11] = '{24'h235959, 1'b1, 1'b0, 24'h115959, 1'b1};
        vecs[12] = '{24'h005960, 1'b1, 1'b1, 24'h115959, 1'b1};

        rst      = 1'b0;
        run_en   = 1'b1;
        mode_12h = 1'b0;
        load     = 1'b0;
        set_time = 24'h000000;

        // Asynchronous reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_display", 64'(segs_all), 64'(disp_of(24'h000000)));
        checkOutput("reset_pm", 64'(pm), 64'(0));
        checkOutput("reset_sec_tick", 64'(sec_tick), 64'(0));
        checkOutput("reset_load_err", 64'(load_err), 64'(0));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

        // Free running: one strobe every fourth cycle, ten seconds after 40 cycles.
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("count_sec_tick_%0d", k), 64'(sec_tick), 64'((k % 4) == 0));
            if (k == 5)
                checkOutput("count_display_1s", 64'(segs_all), 64'(disp_of(24'h000001)));
            if (k == 41)
                checkOutput("count_display_10s", 64'(segs_all), 64'(disp_of(24'h000010)));
        end

        // Paused loads: validation, error pulse and 12/24-hour display.
        run_en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            scoreVector(i);
        end

        // Rollover, coincident load and pause/resume in one timed sequence.
        run_en   = 1'b1;
        mode_12h = 1'b0;
        load     = 1'b1;
        set_time = 24'h235958;
        for (int i = 0; i <= 41; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("seq_sec_tick_%0d", i), 64'(sec_tick),
                        64'((i == 4) || (i == 8) || (i == 16) || (i == 40)));
            case (i)
                1: begin
                    checkOutput("seq_display_235958", 64'(segs_all), 64'(disp_of(24'h235958)));
                    checkOutput("seq_pm_235958", 64'(pm), 64'(1));
                end
                5: begin
                    checkOutput("seq_display_235959", 64'(segs_all), 64'(disp_of(24'h235959)));
                    checkOutput("seq_pm_235959", 64'(pm), 64'(1));
                end
                9: begin
                    checkOutput("seq_display_rollover", 64'(segs_all), 64'(disp_of(24'h000000)));
                    checkOutput("seq_pm_rollover", 64'(pm), 64'(0));
                end
                13: checkOutput("seq_display_coincident_load", 64'(segs_all), 64'(disp_of(24'h120000)));
                17: checkOutput("seq_display_after_load_tick", 64'(segs_all), 64'(disp_of(24'h120001)));
                38: checkOutput("seq_display_frozen", 64'(segs_all), 64'(disp_of(24'h120001)));
                41: begin
                    checkOutput("seq_display_resumed", 64'(segs_all), 64'(disp_of(24'h120002)));
                    checkOutput("seq_pm_resumed", 64'(pm), 64'(1));
                end
                default: ;
            endcase
            case (i)
                0:  load = 1'b0;
                11: begin
                    load     = 1'b1;
                    set_time = 24'h120000;
                end
                12: load = 1'b0;
                18: run_en = 1'b0;
                38: run_en = 1'b1;
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
